// File: rtl/router_switch_allocator_if.sv
// Handshake bundle between the per-channel direction stage, the switch
// allocator and the three output ports.
interface router_switch_allocator_if #(
  parameter int unsigned DW = 40
) ();
  logic          in_valid_x, in_valid_y, in_valid_local;
  logic [DW-1:0] in_data_x,  in_data_y,  in_data_local;
  logic [1:0]    in_dir_x,   in_dir_y,   in_dir_local;
  logic          in_ready_x, in_ready_y, in_ready_local;
  logic          out_valid_x, out_valid_y, out_valid_local;
  logic [DW-1:0] out_data_x,  out_data_y,  out_data_local;
  logic          out_ready_x, out_ready_y, out_ready_local;

  // Environment side: upstream channels and downstream consumers.
  modport master (
    output in_valid_x, in_valid_y, in_valid_local,
    output in_data_x,  in_data_y,  in_data_local,
    output in_dir_x,   in_dir_y,   in_dir_local,
    input  in_ready_x, in_ready_y, in_ready_local,
    input  out_valid_x, out_valid_y, out_valid_local,
    input  out_data_x,  out_data_y,  out_data_local,
    output out_ready_x, out_ready_y, out_ready_local
  );

  // Allocator side.
  modport slave (
    input  in_valid_x, in_valid_y, in_valid_local,
    input  in_data_x,  in_data_y,  in_data_local,
    input  in_dir_x,   in_dir_y,   in_dir_local,
    output in_ready_x, in_ready_y, in_ready_local,
    output out_valid_x, out_valid_y, out_valid_local,
    output out_data_x,  out_data_y,  out_data_local,
    input  out_ready_x, out_ready_y, out_ready_local
  );
endinterface

// File: rtl/router_switch_allocator.sv
// Per-output-port round-robin switch allocator feeding one-entry output
// registers; packets with direction 00 are popped and counted as drops.
module router_switch_allocator #(
  parameter int unsigned DW = 40,
  parameter int unsigned CW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  router_switch_allocator_if.slave bus,
  output logic [CW-1:0]            drop_count
);

  localparam int unsigned NP = 3;
  localparam int unsigned SW = CW + 2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [NP-1:0] in_vld;
  logic [1:0]    in_dir [NP];
  logic [DW-1:0] in_dat [NP];
  logic [NP-1:0] o_rdy;
  logic [NP-1:0] o_vld;
  logic [DW-1:0] o_dat  [NP];
  logic [1:0]    rr_ptr [NP];

  logic [NP-1:0] can_load;
  logic [NP-1:0] grant;
  logic [1:0]    win    [NP];
  logic [1:0]    idx;
  logic [NP-1:0] in_rdy_c;
  logic [NP-1:0] drop_vec;
  logic [1:0]    n_drop;
  logic [SW-1:0] cnt_sum;
  logic [CW-1:0] drop_next;

  assign in_vld = {bus.in_valid_local, bus.in_valid_y, bus.in_valid_x};
  assign in_dir[0] = bus.in_dir_x;
  assign in_dir[1] = bus.in_dir_y;
  assign in_dir[2] = bus.in_dir_local;
  assign in_dat[0] = bus.in_data_x;
  assign in_dat[1] = bus.in_data_y;
  assign in_dat[2] = bus.in_data_local;
  assign o_rdy  = {bus.out_ready_local, bus.out_ready_y, bus.out_ready_x};

  assign bus.in_ready_x      = in_rdy_c[0];
  assign bus.in_ready_y      = in_rdy_c[1];
  assign bus.in_ready_local  = in_rdy_c[2];
  assign bus.out_valid_x     = o_vld[0];
  assign bus.out_valid_y     = o_vld[1];
  assign bus.out_valid_local = o_vld[2];
  assign bus.out_data_x      = o_dat[0];
  assign bus.out_data_y      = o_dat[1];
  assign bus.out_data_local  = o_dat[2];

  // (ptr + k) mod 3 for ptr, k in 0..2.
  function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input logic [1:0] k);
    logic [2:0] sum;
    sum = 3'(ptr) + 3'(k);
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
  endfunction

  // Arbitration: scanning from the far end lets the requester closest to rr_ptr win.
  always_comb begin
    can_load = '0;
    grant    = '0;
    idx      = '0;
    in_rdy_c = '0;
    drop_vec = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      win[p]      = '0;
      can_load[p] = !o_vld[p] || o_rdy[p];
      for (int k = int'(NP) - 1; k >= 0; k--) begin
        idx = rr_idx(rr_ptr[p], 2'(k));
        if (can_load[p] && in_vld[idx] && (in_dir[idx] == 2'(p + 1))) begin
          grant[p] = 1'b1;
          win[p]   = idx;
        end
      end
    end
    for (int unsigned i = 0; i < NP; i++) begin
      drop_vec[i] = in_vld[i] && (in_dir[i] == 2'd0);
      in_rdy_c[i] = drop_vec[i];
      for (int unsigned p = 0; p < NP; p++) begin
        if (grant[p] && (win[p] == 2'(i))) in_rdy_c[i] = 1'b1;
      end
    end
    if (rst) begin
      in_rdy_c = '0;
      drop_vec = '0;
    end
  end

  // Saturating drop counter, counting every discarded packet.
  always_comb begin
    n_drop    = 2'(drop_vec[0]) + 2'(drop_vec[1]) + 2'(drop_vec[2]);
    cnt_sum   = SW'(drop_count) + SW'(n_drop);
    drop_next = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : CW'(cnt_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < NP; p++) begin
        o_vld[p]  <= 1'b0;
        o_dat[p]  <= '0;
        rr_ptr[p] <= 2'd0;
      end
      drop_count <= '0;
    end else begin
      for (int unsigned p = 0; p < NP; p++) begin
        if (grant[p]) begin
          o_dat[p]  <= in_dat[win[p]];
          o_vld[p]  <= 1'b1;
          rr_ptr[p] <= (win[p] == 2'd2) ? 2'd0 : win[p] + 2'd1;
        end else if (o_rdy[p]) begin
          o_vld[p]  <= 1'b0;
        end
      end
      drop_count <= drop_next;
    end
  end

endmodule

// File: tb/tb_router_switch_allocator.sv
// Scoreboard bench for router_switch_allocator: expected packets are queued
// per output port at drive time and compared as each output handshake occurs.
module tb_router_switch_allocator;

  localparam int unsigned DW = 40;
  localparam int unsigned CW = 8;

  localparam logic [DW-1:0] D_SINGLE = 40'hA5_0000_1234;
  localparam logic [DW-1:0] D_X      = 40'h11_0000_0001;
  localparam logic [DW-1:0] D_Y      = 40'h22_0000_0002;
  localparam logic [DW-1:0] D_L      = 40'h33_0000_0003;
  localparam logic [DW-1:0] D_B0     = 40'h44_0000_00B0;
  localparam logic [DW-1:0] D_B1     = 40'h55_0000_00B1;
  localparam logic [DW-1:0] D_PX     = 40'h66_0000_0C01;
  localparam logic [DW-1:0] D_PY     = 40'h77_0000_0C02;
  localparam logic [DW-1:0] D_PL     = 40'h88_0000_0C03;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] drop_count;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] q_x[$];
  logic [DW-1:0] q_y[$];
  logic [DW-1:0] q_l[$];

  router_switch_allocator_if #(.DW(DW)) bus ();

  router_switch_allocator #(.DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid_x = 1'b0; bus.in_valid_y = 1'b0; bus.in_valid_local = 1'b0;
    bus.in_dir_x   = 2'd0; bus.in_dir_y   = 2'd0; bus.in_dir_local   = 2'd0;
    bus.in_data_x  = '0;   bus.in_data_y  = '0;   bus.in_data_local  = '0;
  endtask

  task automatic set_ready(input logic rx, input logic ry, input logic rl);
    bus.out_ready_x = rx; bus.out_ready_y = ry; bus.out_ready_local = rl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rdy_vec();
    return {bus.in_ready_local, bus.in_ready_y, bus.in_ready_x};
  endfunction

  // Output monitor: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid_x && bus.out_ready_x) begin
        if (q_x.size() == 0) check("x_unexpected", 64'(bus.out_data_x), 64'hDEAD);
        else check("x_data", 64'(bus.out_data_x), 64'(q_x.pop_front()));
      end
      if (bus.out_valid_y && bus.out_ready_y) begin
        if (q_y.size() == 0) check("y_unexpected", 64'(bus.out_data_y), 64'hDEAD);
        else check("y_data", 64'(bus.out_data_y), 64'(q_y.pop_front()));
      end
      if (bus.out_valid_local && bus.out_ready_local) begin
        if (q_l.size() == 0) check("l_unexpected", 64'(bus.out_data_local), 64'hDEAD);
        else check("l_data", 64'(bus.out_data_local), 64'(q_l.pop_front()));
      end
    end
  end

  initial begin
    logic [2:0] rr_exp [6];
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

    // Reset with every input requesting X.
    rst = 1'b1;
    set_ready(1'b1, 1'b1, 1'b1);
    bus.in_valid_x = 1'b1; bus.in_valid_y = 1'b1; bus.in_valid_local = 1'b1;
    bus.in_dir_x   = 2'd1; bus.in_dir_y   = 2'd1; bus.in_dir_local   = 2'd1;
    bus.in_data_x  = D_X;  bus.in_data_y  = D_Y;  bus.in_data_local  = D_L;
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", 64'(rdy_vec()), 64'd0);
      check("rst_out_valid", 64'({bus.out_valid_local, bus.out_valid_y, bus.out_valid_x}), 64'd0);
      check("rst_out_data_or", 64'(bus.out_data_x | bus.out_data_y | bus.out_data_local), 64'd0);
      check("rst_drop", 64'(drop_count), 64'd0);
    end
    next_cycle();
    idle_inputs();
    rst = 1'b0;

    // Single packet Y -> Local.
    bus.in_valid_y = 1'b1; bus.in_dir_y = 2'd3; bus.in_data_y = D_SINGLE;
    q_l.push_back(D_SINGLE);
    @(negedge clk);
    check("single_in_ready", 64'(rdy_vec()), 64'b010);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("single_out_valid", 64'(bus.out_valid_local), 64'd1);
    check("single_out_data", 64'(bus.out_data_local), 64'(D_SINGLE));
    next_cycle();
    @(negedge clk);
    check("single_drained", 64'(bus.out_valid_local), 64'd0);
    next_cycle();

    // Round-robin on port X with all three inputs requesting continuously.
    bus.in_valid_x = 1'b1; bus.in_valid_y = 1'b1; bus.in_valid_local = 1'b1;
    bus.in_dir_x   = 2'd1; bus.in_dir_y   = 2'd1; bus.in_dir_local   = 2'd1;
    bus.in_data_x  = D_X;  bus.in_data_y  = D_Y;  bus.in_data_local  = D_L;
    for (int i = 0; i < 6; i++) begin
      case (rr_exp[i])
        3'b001:  q_x.push_back(D_X);
        3'b010:  q_x.push_back(D_Y);
        default: q_x.push_back(D_L);
      endcase
      @(negedge clk);
      check("rr_grant", 64'(rdy_vec()), 64'(rr_exp[i]));
      if (i > 0) check("rr_out_valid", 64'(bus.out_valid_x), 64'd1);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();

    // Backpressure on port X.
    bus.in_valid_x = 1'b1; bus.in_dir_x = 2'd1; bus.in_data_x = D_B0;
    q_x.push_back(D_B0);
    @(negedge clk);
    check("bp_first_grant", 64'(bus.in_ready_x), 64'd1);
    next_cycle();
    bus.in_data_x = D_B1;
    set_ready(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_stall_ready", 64'(bus.in_ready_x), 64'd0);
      check("bp_stall_valid", 64'(bus.out_valid_x), 64'd1);
      check("bp_stall_data", 64'(bus.out_data_x), 64'(D_B0));
      next_cycle();
    end
    set_ready(1'b1, 1'b1, 1'b1);
    q_x.push_back(D_B1);
    @(negedge clk);
    check("bp_release_ready", 64'(bus.in_ready_x), 64'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("bp_new_data", 64'(bus.out_data_x), 64'(D_B1));
    next_cycle();
    next_cycle();

    // Parallel crossing plus one drop.
    bus.in_valid_x = 1'b1; bus.in_valid_y = 1'b1; bus.in_valid_local = 1'b1;
    bus.in_dir_x   = 2'd2; bus.in_dir_y   = 2'd1; bus.in_dir_local   = 2'd0;
    bus.in_data_x  = D_PX; bus.in_data_y  = D_PY; bus.in_data_local  = D_PL;
    q_y.push_back(D_PX);
    q_x.push_back(D_PY);
    @(negedge clk);
    check("par_in_ready", 64'(rdy_vec()), 64'b111);
    check("par_drop_before", 64'(drop_count), 64'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("par_drop_after", 64'(drop_count), 64'd1);
    check("par_out_valid", 64'({bus.out_valid_local, bus.out_valid_y, bus.out_valid_x}), 64'b011);
    next_cycle();

    // Drop counter saturation.
    bus.in_valid_x = 1'b1; bus.in_dir_x = 2'd0; bus.in_data_x = D_X;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      check("sat_in_ready", 64'(bus.in_ready_x), 64'd1);
      check("sat_count", 64'(drop_count), (i + 1 > 255) ? 64'd255 : 64'(i + 1));
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("sat_final", 64'(drop_count), 64'd255);
    next_cycle();

    // Fill all ports under backpressure, then reset mid-operation.
    set_ready(1'b0, 1'b0, 1'b0);
    bus.in_valid_x = 1'b1; bus.in_valid_y = 1'b1; bus.in_valid_local = 1'b1;
    bus.in_dir_x   = 2'd1; bus.in_dir_y   = 2'd2; bus.in_dir_local   = 2'd3;
    bus.in_data_x  = D_X;  bus.in_data_y  = D_Y;  bus.in_data_local  = D_L;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("fill_out_valid", 64'({bus.out_valid_local, bus.out_valid_y, bus.out_valid_x}), 64'b111);
    check("fill_data_y", 64'(bus.out_data_y), 64'(D_Y));
    next_cycle();
    rst = 1'b1;
    bus.in_valid_x = 1'b1; bus.in_dir_x = 2'd0;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(rdy_vec()), 64'd0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("post_rst_valid", 64'({bus.out_valid_local, bus.out_valid_y, bus.out_valid_x}), 64'd0);
    check("post_rst_data_or", 64'(bus.out_data_x | bus.out_data_y | bus.out_data_local), 64'd0);
    check("post_rst_drop", 64'(drop_count), 64'd0);
    next_cycle();

    check("q_x_empty", 64'(q_x.size()), 64'd0);
    check("q_y_empty", 64'(q_y.size()), 64'd0);
    check("q_l_empty", 64'(q_l.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
